// File: rtl/program_counter_stk.sv
// Program counter with increment, relative branch, absolute jump and an optional
// hardware call/return stack (enabled by defining PC_RET_STACK_EN).
module program_counter_stk #(
  parameter int             AW        = 8,
  parameter int             OW        = 6,
  parameter int             DEPTH     = 4,
  parameter logic [AW-1:0]  RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          pi,
  input  logic          pl,
  input  logic          pj,
  input  logic          call,
  input  logic          ret,
  input  logic [OW-1:0] ad,
  input  logic [AW-1:0] ja,
  output logic [AW-1:0] add_out,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          cmd_err,
  output logic          stk_err
);

  function automatic logic signed [AW-1:0] sext_off(input logic signed [OW-1:0] v);
    logic signed [AW-1:0] r;
    r = v;
    return r;
  endfunction

  logic [2:0]    n_cmd;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_nxt;
  logic          cmd_err_nxt;

  assign n_cmd  = 3'(pi) + 3'(pl) + 3'(pj) + 3'(call) + 3'(ret);
  assign pc_inc = add_out + AW'(1);

`ifdef PC_RET_STACK_EN
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] stk_mem [DEPTH];
  logic          push;
  logic          stk_err_nxt;
  logic          is_full;
  logic          is_empty;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic [CW-1:0] cnt_dec;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);
  assign cnt_dec  = cnt - CW'(1);
  assign wr_idx   = cnt[PW-1:0];
  assign rd_idx   = cnt_dec[PW-1:0];

  always_comb begin
    pc_nxt      = add_out;
    cnt_nxt     = cnt;
    push        = 1'b0;
    cmd_err_nxt = 1'b0;
    stk_err_nxt = 1'b0;
    if (!stall) begin
      if (n_cmd > 3'd1) begin
        cmd_err_nxt = 1'b1;
      end else if (pi) begin
        pc_nxt = pc_inc;
      end else if (pl) begin
        pc_nxt = add_out + sext_off(ad);
      end else if (pj) begin
        pc_nxt = ja;
      end else if (call) begin
        if (is_full) begin
          stk_err_nxt = 1'b1;
        end else begin
          push    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          pc_nxt  = ja;
        end
      end else if (ret) begin
        if (is_empty) begin
          stk_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
          pc_nxt  = stk_mem[rd_idx];
        end
      end
    end
  end

  // Return-address storage carries no reset; only the count qualifies it.
  always_ff @(posedge clk) begin
    if (push) stk_mem[wr_idx] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_out   <= RESET_VEC;
      cnt       <= '0;
      stk_empty <= 1'b1;
      stk_full  <= 1'b0;
      cmd_err   <= 1'b0;
      stk_err   <= 1'b0;
    end else begin
      add_out   <= pc_nxt;
      cnt       <= cnt_nxt;
      stk_empty <= (cnt_nxt == '0);
      stk_full  <= (cnt_nxt == CW'(DEPTH));
      cmd_err   <= cmd_err_nxt;
      stk_err   <= stk_err_nxt;
    end
  end
`else
  // Without a stack, call and ret are treated as illegal opcodes.
  always_comb begin
    pc_nxt      = add_out;
    cmd_err_nxt = 1'b0;
    if (!stall) begin
      if (n_cmd > 3'd1 || call || ret) begin
        cmd_err_nxt = 1'b1;
      end else if (pi) begin
        pc_nxt = pc_inc;
      end else if (pl) begin
        pc_nxt = add_out + sext_off(ad);
      end else if (pj) begin
        pc_nxt = ja;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_out <= RESET_VEC;
      cmd_err <= 1'b0;
    end else begin
      add_out <= pc_nxt;
      cmd_err <= cmd_err_nxt;
    end
  end

  assign stk_empty = 1'b1;
  assign stk_full  = 1'b0;
  assign stk_err   = 1'b0;
`endif

endmodule

// File: doc/program_counter_stk.md
Name: program_counter_stk

Overview:
- Parametrised successor to the processor's 6-bit-offset program counter.
- Provides sequential increment, PC-relative branch with a sign-extended offset, absolute jump, and a hardware call/return stack.
- Sits between the instruction decoder (command strobes, offset/target fields) and instruction memory (drives the fetch address).
- Adds explicit reset, a stall input, command-conflict detection and stack-fault reporting.

Parameters:
- AW, 8, program address width in bits; wrap is modulo 2^AW.
- OW, 6, relative offset width in bits; two's complement, sign-extended to AW.
- DEPTH, 4, return-stack entries; power of two, at least 2.
- RESET_VEC, 0, value loaded into add_out on reset; AW bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freezes PC, stack and all commands when 1.
- pi  in  1  increment command.
- pl  in  1  relative branch command, add_out + sext(ad).
- pj  in  1  absolute jump command, add_out = ja.
- call  in  1  push add_out+1, then jump to ja.
- ret  in  1  pop the top of stack into add_out.
- ad  in  OW  relative offset, signed.
- ja  in  AW  absolute target for pj and call.
- add_out  out  AW  current fetch address (registered).
- stk_empty  out  1  stack holds 0 entries.
- stk_full  out  1  stack holds DEPTH entries.
- cmd_err  out  1  one-cycle pulse on an illegal command combination.
- stk_err  out  1  one-cycle pulse on stack overflow or underflow.

Behaviour:
- Reset:
  - rst_n low asynchronously sets add_out=RESET_VEC, stack count=0, stk_empty=1, stk_full=0, cmd_err=0, stk_err=0.
  - Stack entry contents are don't-care after reset.
  - Reset asserted mid-operation aborts any command in flight; no partial push or pop survives.
- Latency:
  - A command sampled at rising edge N is reflected in add_out after edge N.
  - All outputs are registered; there is no combinational path from inputs to outputs.
- stall=1:
  - No state change.
  - cmd_err and stk_err are 0 in that cycle.
  - Commands are ignored, not queued.
- Command decode (stall=0): exactly one of pi, pl, pj, call, ret is required.
  - None asserted: add_out holds.
  - Two or more asserted: add_out and stack hold; cmd_err=1 for one cycle. This generalises the old rule that pi and pl together hold.
- pi: add_out <= add_out + 1 (mod 2^AW). AW'1s wraps to 0.
- pl:
  - add_out <= add_out + sext(ad) (mod 2^AW). The sign bit is ad[OW-1].
  - Example, AW=8, OW=6: ad=6'h20 gives offset 8'hE0, i.e. -32.
- pj: add_out <= ja.
- call:
  - Not full: stack[top] <= add_out+1 (mod 2^AW); count++; add_out <= ja.
  - Full: no push, add_out holds, stk_err=1 for one cycle.
- ret:
  - Not empty: add_out <= stack[top-1]; count--.
  - Empty: add_out holds, stk_err=1 for one cycle.
- Flags:
  - stk_empty = (count==0) and stk_full = (count==DEPTH), both registered.
  - Flags update in the same edge as the push or pop.
- Stack is LIFO; the count register is $clog2(DEPTH)+1 bits wide.

Optional Feature:
- Macro: PC_RET_STACK_EN.
- Defined: the call/ret return stack operates as described above.
- Undefined:
  - No stack storage is built.
  - call or ret asserted alone (stall=0) is treated as illegal: add_out holds and cmd_err=1.
  - stk_empty tied to 1, stk_full to 0, stk_err to 0.

Test Plan (AW=8, OW=6, DEPTH=4, RESET_VEC=8'h10):
- Release rst_n, then pi for 3 cycles -> add_out 8'h10, 8'h11, 8'h12, 8'h13. With add_out=8'hFF, pi -> 8'h00.
- add_out=8'h40: pl, ad=6'h05 -> 8'h45; then pl, ad=6'h3B (-5) -> 8'h40; from 8'h02, pl, ad=6'h20 (-32) -> 8'hE2.
- add_out=8'h20: call, ja=8'h80 -> add_out 8'h80, stk_empty=0; pi -> 8'h81; ret -> 8'h21, stk_empty=1.
- Four nested calls -> stk_full=1; a fifth call -> add_out unchanged, stk_err pulse. Five rets -> four correct return addresses, then a stk_err pulse on the fifth.
- pi+pl together -> add_out held, cmd_err=1 for one cycle. stall=1 with pj, ja=8'h55 -> add_out unchanged, no error.
- Assert rst_n low mid-cycle during a call -> add_out=8'h10 immediately, stk_empty=1. Rebuild without PC_RET_STACK_EN: call -> cmd_err=1, add_out held.
